// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the 7-segment display scanner and any other 7-segment consumer.
// Holds the digit/frame sizes, the scanner FSM state encoding and the BCD segment table.
// Segment codes are active-high {g,f,e,d,c,b,a}; BCD 10..15 decode to blank.
package seven_seg_scanner_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int FRAME_BITS = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    CAPTURE = 3'd2,
    SHIFT   = 3'd3,
    LATCH   = 3'd4
  } state_t;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

endpackage

// File: rtl/seven_seg_scanner_decode.sv
// bcd_to_7seg: combinational BCD digit to active-high 7-segment pattern {g,f,e,d,c,b,a}.
// Zero latency; no handshake.
// Codes 10..15 produce a blank digit.
module bcd_to_7seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_bcd];

endmodule

// File: rtl/seven_seg_scanner.sv
// Scans six display digits: selects a digit upstream, captures its BCD value, and shifts a
// 16-bit {dp,segments,active-low enables} frame MSB-first into a 74HC595 chain, then latches.
// One frame takes 2 + 33*SCLK_DIV cycles; ticks arriving while busy are dropped, never queued.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic [3:0] i_bcd,
  input  logic       i_dp,
  output logic [3:0] o_seg_select,
  output logic       o_serial_data,
  output logic       o_serial_clk,
  output logic       o_serial_latch,
  output logic       o_busy
);

  localparam int               DIV_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCLK_DIV - 1);
  localparam logic [2:0]       LAST_DIGIT = 3'(NUM_DIGITS - 1);
  localparam logic [3:0]       LAST_BIT   = 4'(FRAME_BITS - 1);

  state_t                state_q;
  logic [2:0]            digit_q;
  logic [3:0]            bit_q;
  logic [DIV_W-1:0]      div_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  sclk_q;
  logic                  latch_q;
  logic                  busy_q;

  logic [6:0]            seg_d;
  logic [7:0]            enable_d;
  logic [FRAME_BITS-1:0] frame_d;
  logic                  div_done_d;

  bcd_to_7seg u_decode (
    .i_bcd (i_bcd),
    .o_seg (seg_d)
  );

  // Assemble the frame for the digit currently selected upstream; only sampled in CAPTURE.
  always_comb begin
    enable_d = ~(8'h01 << digit_q);
    frame_d  = {i_dp, seg_d, enable_d};
  end

  assign div_done_d = (div_q == DIV_LAST);

  // Scanner FSM: all outputs come straight from these registers, so no input reaches an output
  // combinationally. Serial data is the frame MSB and changes only as the clock goes low.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      digit_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      frame_q <= '0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_tick) begin
            state_q <= SELECT;
            busy_q  <= 1'b1;
          end
        end
        SELECT: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          frame_q <= frame_d;
          bit_q   <= '0;
          div_q   <= '0;
          sclk_q  <= 1'b0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (div_done_d) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == LAST_BIT) begin
                frame_q <= '0;
                bit_q   <= '0;
                latch_q <= 1'b1;
                state_q <= LATCH;
              end else begin
                frame_q <= frame_q << 1;
                bit_q   <= bit_q + 4'd1;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        LATCH: begin
          if (div_done_d) begin
            div_q   <= '0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            digit_q <= (digit_q == LAST_DIGIT) ? 3'd0 : digit_q + 3'd1;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_seg_select   = {1'b0, digit_q};
  assign o_serial_data  = frame_q[FRAME_BITS-1];
  assign o_serial_clk   = sclk_q;
  assign o_serial_latch = latch_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: two instances (SCLK_DIV=2 and SCLK_DIV=1) share a
// table that plays the upstream digit selector. Stimulus pushes expected frames; a monitor
// deserialises each instance's serial stream and checks frame, bit count, timing on every latch.
module tb_seven_seg_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick0 = 1'b0;
  logic       tick1 = 1'b0;
  logic [3:0] bcd0, bcd1, sel0, sel1;
  logic       dp0, dp1;
  logic [1:0] sdat, sclk, latch, busy;

  logic [3:0] dig_tab [16];
  logic       dp_tab  [16];

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] exp0 [$];
  logic [15:0] exp1 [$];
  bit          burst = 1'b0;
  int          md [2];

  always #5 clk = ~clk;

  // Upstream selector model: digit value is a combinational lookup of the DUT's select.
  assign bcd0 = dig_tab[sel0];
  assign dp0  = dp_tab[sel0];
  assign bcd1 = dig_tab[sel1];
  assign dp1  = dp_tab[sel1];

  seven_seg_scanner #(.SCLK_DIV(2)) dut_a (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_tick         (tick0),
    .i_bcd          (bcd0),
    .i_dp           (dp0),
    .o_seg_select   (sel0),
    .o_serial_data  (sdat[0]),
    .o_serial_clk   (sclk[0]),
    .o_serial_latch (latch[0]),
    .o_busy         (busy[0])
  );

  seven_seg_scanner #(.SCLK_DIV(1)) dut_b (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_tick         (tick1),
    .i_bcd          (bcd1),
    .i_dp           (dp1),
    .o_seg_select   (sel1),
    .o_serial_data  (sdat[1]),
    .o_serial_clk   (sclk[1]),
    .o_serial_latch (latch[1]),
    .o_busy         (busy[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int divk(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Hand-written reference frame: {dp, segments, active-low enable for digit d}.
  function automatic logic [15:0] ref_frame(input int d, input logic [3:0] b, input logic p);
    logic [6:0] s;
    logic [7:0] en;
    case (b)
      4'd0: s = 7'h3F;  4'd1: s = 7'h06;  4'd2: s = 7'h5B;  4'd3: s = 7'h4F;
      4'd4: s = 7'h66;  4'd5: s = 7'h6D;  4'd6: s = 7'h7D;  4'd7: s = 7'h07;
      4'd8: s = 7'h7F;  4'd9: s = 7'h6F;  default: s = 7'h00;
    endcase
    en = 8'hFF;
    en[d] = 1'b0;
    return {p, s, en};
  endfunction

  // ---------------- monitor ----------------
  logic [15:0] got_f      [2];
  int          nbits      [2];
  int          since_rise [2];
  int          busy_cnt   [2];
  int          latch_cnt  [2];
  int          gap_cnt    [2];
  bit          gap_ok     [2];
  logic        prev_sclk  [2];
  logic        prev_busy  [2];
  logic        prev_latch [2];

  // Sample on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        got_f[k] = '0; nbits[k] = 0; since_rise[k] = 0; busy_cnt[k] = 0;
        latch_cnt[k] = 0; gap_cnt[k] = 0; gap_ok[k] = 1'b0;
      end else begin
        since_rise[k]++;
        if (sclk[k] && !prev_sclk[k]) begin
          if (nbits[k] > 0) chk($sformatf("sclk_period%0d", k), since_rise[k], 2 * divk(k));
          since_rise[k] = 0;
          got_f[k] = {got_f[k][14:0], sdat[k]};
          nbits[k]++;
        end
        if (latch[k] && !prev_latch[k]) begin
          chk($sformatf("frame_bits%0d", k), nbits[k], 16);
          if (k == 0) begin
            if (exp0.size() == 0) chk("queue0_nonempty_at_latch", exp0.size(), 1);
            else chk("frame0", got_f[k], exp0.pop_front());
          end else begin
            if (exp1.size() == 0) chk("queue1_nonempty_at_latch", exp1.size(), 1);
            else chk("frame1", got_f[k], exp1.pop_front());
          end
          nbits[k] = 0;
        end
        if (latch[k]) latch_cnt[k]++;
        if (!latch[k] && prev_latch[k]) begin
          chk($sformatf("latch_width%0d", k), latch_cnt[k], divk(k));
          latch_cnt[k] = 0;
        end
        if (busy[k]) busy_cnt[k]++;
        if (busy[k] && !prev_busy[k]) begin
          if (gap_ok[k] && burst) chk($sformatf("idle_gap%0d", k), gap_cnt[k], 1);
          gap_ok[k] = 1'b0;
        end
        if (!busy[k] && prev_busy[k]) begin
          chk($sformatf("busy_len%0d", k), busy_cnt[k], 2 + 33 * divk(k));
          busy_cnt[k] = 0;
          gap_cnt[k] = 1;
          gap_ok[k] = burst;
        end else if (!busy[k]) begin
          gap_cnt[k]++;
        end
      end
      prev_sclk[k]  = sclk[k];
      prev_busy[k]  = busy[k];
      prev_latch[k] = latch[k];
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k);
    @(negedge clk);
    if (k == 0) tick0 = 1'b1; else tick1 = 1'b1;
    @(negedge clk);
    tick0 = 1'b0;
    tick1 = 1'b0;
    chk($sformatf("busy_raised%0d", k), busy[k], 1);
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (busy[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk($sformatf("idle_timeout%0d", k), busy[k], 0);
  endtask

  task automatic send(input int k, input logic [3:0] b, input logic p, input logic [15:0] want);
    dig_tab[md[k]] = b;
    dp_tab[md[k]]  = p;
    if (k == 0) exp0.push_back(want); else exp1.push_back(want);
    tick(k);
    wait_idle(k);
    md[k] = (md[k] + 1) % 6;
    repeat (2) @(negedge clk);
    chk($sformatf("seg_select%0d", k), (k == 0) ? sel0 : sel1, md[k]);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    md[0] = 0;
    md[1] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      dig_tab[i] = 4'd0;
      dp_tab[i]  = 1'b0;
    end
    md[0] = 0;
    md[1] = 0;
    repeat (3) @(negedge clk);
    chk("rst_sel", sel0, 0);
    chk("rst_data", sdat[0], 0);
    chk("rst_sclk", sclk[0], 0);
    chk("rst_latch", latch[0], 0);
    chk("rst_busy", busy[0], 0);
    #2 rst = 1'b0;

    // Digit 0 shows "1", no dp.
    send(0, 4'd1, 1'b0, 16'h06FE);

    // Fresh reset, then six ticks of "8." ending on digit 5, then wrap to digit 0.
    do_reset();
    chk("reset_sel_after_frame", sel0, 0);
    for (int d = 0; d < 5; d++) send(0, 4'd8, 1'b1, ref_frame(d, 4'd8, 1'b1));
    send(0, 4'd8, 1'b1, 16'hFFDF);
    send(0, 4'd8, 1'b1, 16'hFFFE);

    // Digit 1 "0", digit 2 blank code 0xB, digit 3 blank 0xF with dp.
    send(0, 4'd0, 1'b0, 16'h3FFD);
    send(0, 4'hB, 1'b0, 16'h00FB);
    send(0, 4'hF, 1'b1, 16'h80F7);

    // Tick held for 200 cycles from digit 4: three frames, one idle cycle apart.
    dig_tab[4] = 4'd7; dp_tab[4] = 1'b0;
    dig_tab[5] = 4'd7; dp_tab[5] = 1'b0;
    dig_tab[0] = 4'd7; dp_tab[0] = 1'b0;
    exp0.push_back(16'h07EF);
    exp0.push_back(16'h07DF);
    exp0.push_back(16'h07FE);
    burst = 1'b1;
    @(negedge clk);
    tick0 = 1'b1;
    repeat (200) @(negedge clk);
    tick0 = 1'b0;
    wait_idle(0);
    burst = 1'b0;
    md[0] = 1;
    repeat (10) @(negedge clk);
    chk("no_queued_tick_busy", busy[0], 0);
    chk("burst_seg_select", sel0, 1);
    chk("burst_frames_drained", exp0.size(), 0);

    // Reset in the middle of SHIFT: outputs clear at once and the frame never latches.
    tick(0);
    repeat (20) @(negedge clk);
    chk("midshift_busy", busy[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_sel", sel0, 0);
    chk("abort_data", sdat[0], 0);
    chk("abort_sclk", sclk[0], 0);
    chk("abort_latch", latch[0], 0);
    chk("abort_busy", busy[0], 0);
    @(negedge clk);
    #2 rst = 1'b0;
    md[0] = 0;
    md[1] = 0;
    repeat (80) @(negedge clk);
    send(0, 4'd5, 1'b0, 16'h6DFE);

    // SCLK_DIV=1 instance: same frame contents, faster serial clock.
    send(1, 4'd1, 1'b0, 16'h06FE);
    send(1, 4'd8, 1'b1, 16'hFFFD);
    send(1, 4'hB, 1'b0, 16'h00FB);

    repeat (5) @(negedge clk);
    chk("exp0_drained", exp0.size(), 0);
    chk("exp1_drained", exp1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed display scanner that sits directly downstream of the binary-to-BCD digit selector. On each refresh tick it drives that block's 4-bit digit select and captures the returned BCD digit and decimal point. It decodes them to 7-segment form and shifts a 16-bit frame (segments plus active-low digit enable) into an external 74HC595-style shift-register chain, then pulses the latch. Six digits are scanned in order, hours MSD (select 0) to seconds LSD (select 5).

## Interface
- `SCLK_DIV`, default 2: serial clock half-period in `i_clk` cycles; legal range ≥ 1.
- `i_clk`  in  1: system clock; all logic on rising edge.
- `i_reset`  in  1: reset; asynchronous, active-high.
- `i_tick`  in  1: single-cycle refresh strobe; starts one digit frame.
- `i_bcd`  in  4: BCD digit returned by the upstream selector (combinational from `o_seg_select`).
- `i_dp`  in  1: decimal point for the selected digit.
- `o_seg_select`  out  4: digit being scanned, 0..5.
- `o_serial_data`  out  1: shift data, MSB of frame first.
- `o_serial_clk`  out  1: shift clock; the shift register samples on the rising edge.
- `o_serial_latch`  out  1: storage-register latch pulse, active-high.
- `o_busy`  out  1: high from acceptance of `i_tick` until the end of LATCH.

## Operation
- **FSM states:** IDLE, SELECT, CAPTURE, SHIFT, LATCH.
- **IDLE:**
  - If `i_tick`=1, go to SELECT and raise `o_busy`.
  - `o_seg_select` always equals the internal digit counter.
- **SELECT:** one cycle, allowing the upstream combinational path to settle.
- **CAPTURE:** one cycle; registers the frame:
  - Frame bits [15:8] = segments {dp,g,f,e,d,c,b,a}, active-high, from the `bcd_to_7seg` decode of `i_bcd`, with dp = `i_dp`.
  - Frame bits [7:0] = digit enables, active-low. Bit n is 0 only for n = digit counter; bits 7:6 are always 1.
- **Segment codes (0–9):** 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D, 0x07, 0x7F, 0x6F. BCD 10–15 produce blank (0x00); dp is still applied.
- **SHIFT:** 16 bits, MSB first. For each bit:
  - `o_serial_data` is updated at the start of the low phase.
  - `o_serial_clk` is low for `SCLK_DIV` cycles, then high for `SCLK_DIV` cycles.
- **LATCH:**
  - `o_serial_clk`=0 and `o_serial_latch`=1 for `SCLK_DIV` cycles.
  - Then the digit counter increments (5 wraps to 0), `o_busy` drops, and the FSM returns to IDLE.
- **Ticks while busy:** `i_tick` while `o_busy`=1 is dropped and not queued. A tick arriving in the same cycle LATCH ends is also dropped.
- **Reset, including mid-frame:**
  - FSM goes to IDLE, digit counter to 0, bit counter to 0.
  - All outputs go to 0: `o_seg_select`=0, data/clk/latch=0, `o_busy`=0.
  - An aborted frame never latches, so the external display keeps its previous frame.

## Timing
- A tick accepted at cycle T puts the FSM in SELECT at T+1, CAPTURE at T+2, and SHIFT from T+3.
- SHIFT lasts 32·`SCLK_DIV` cycles; LATCH lasts `SCLK_DIV` cycles.
- `o_busy` is high for 2 + 33·`SCLK_DIV` cycles (68 at default), then low. The next tick is accepted the cycle after.
- Data setup to the serial clock rising edge is `SCLK_DIV` cycles; hold is `SCLK_DIV` cycles.
- All outputs are registered; no combinational input-to-output path exists.
- `o_seg_select` changes only on the cycle LATCH completes, or on reset.

## Structure
- **Shared package/header:**
  - `NUM_DIGITS`=6, `FRAME_BITS`=16.
  - FSM state encodings.
  - The 16-entry segment-code table, shared with any other 7-segment consumer.
- **Sub-module:** `bcd_to_7seg`, the combinational 4-bit → 7-segment decoder (blank for 10–15).
- **Top-level contents:** FSM, digit counter (mod 6), bit counter (0..15), phase divider counter, and a 16-bit shift register.

## Test plan
- After reset, tick with `i_bcd`=1, `i_dp`=0 → shifted frame 0x06FE; `o_busy` high for exactly 68 cycles; one latch pulse 2 cycles wide; `o_seg_select` becomes 1.
- Six ticks with `i_bcd`=8 and `i_dp`=1 on digit 5 → sixth frame 0xFFDF. `o_seg_select` wraps 5→0, and the seventh frame's enable byte is 0xFE.
- Digit 2 with `i_bcd`=0xB, `i_dp`=0 → frame 0x00FB (segments blank).
- Tick repeated every cycle for 200 cycles → frames back-to-back with exactly one idle cycle between; no tick is queued while busy.
- Assert `i_reset` in the middle of SHIFT → all outputs 0 immediately; no latch pulse; next tick sends digit 0.
- `SCLK_DIV`=1 → serial clock period 2 cycles, busy 35 cycles; frame contents identical to the `SCLK_DIV`=2 run.
